rtlmem_2rw_px: RTL and testbench
================================

Name: rtlmem_2rw_px

Overview:
- Parametrised successor to the 2-port shared read/write memory wrapper; single clock, self-contained inferred RAM array.
- Adds programmable read latency (1..3 cycles) and a per-port read-valid flag.
- Adds an internal clear engine with optional auto-clear after reset.
- Adds defined same-address collision handling with a collision pulse.
- Sits under engines needing a dual-port table (lookup/statistics) with guaranteed clean contents after reset.

Parameters:
- G_ADDR, 10, address width, both ports.
- G_WIDTH, 16, data width, both ports.
- G_DEPTH, 2**G_ADDR, number of words; must be <= 2**G_ADDR.
- G_PIPE, 1, read latency in cycles; legal values 1, 2, 3.
- G_RST_VAL, {G_WIDTH{1'b0}}, value written by the clear engine and returned for out-of-range reads.
- G_WRPRI, "A", port whose write wins on a same-address simultaneous write; "A" or "B".
- G_CLR_ON_RST, 1, 1 = clear engine starts automatically on reset release.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  reset, asynchronous, active-high.
- clren  in  1  level request to clear the whole RAM; sampled only in IDLE.
- clrrdy  out  1  1 = clear engine idle, RAM usable.
- memad_a  in  G_ADDR  port A address.
- memwe_a  in  1  port A write enable.
- memdi_a  in  G_WIDTH  port A write data.
- memre_a  in  1  port A read enable.
- memdo_a  out  G_WIDTH  port A read data; zero when memvld_a=0.
- memvld_a  out  1  port A read data valid.
- memad_b, memwe_b, memdi_b, memre_b, memdo_b, memvld_b  same as port A, for port B.
- colerr  out  1  one-cycle pulse on a same-address simultaneous write.

Behaviour:
- Reset (rst=1, async): memdo_a/b=0, memvld_a/b=0, colerr=0, read pipelines flushed, clear address counter=0.
- Reset state: CLR and clrrdy=0 if G_CLR_ON_RST=1; otherwise IDLE and clrrdy=1.
- RAM contents are not touched by rst itself; only the clear engine writes them.
- FSM IDLE: clrrdy=1; clren=1 -> CLR on next edge, clrrdy=0 from that edge.
- FSM CLR: writes G_RST_VAL at counter address each cycle, counter 0..G_DEPTH-1.
  - After writing address G_DEPTH-1: back to IDLE; clrrdy=1 on the following edge.
  - A clear occupies exactly G_DEPTH cycles; clren is ignored while in CLR.
- During CLR, user writes are dropped and user reads are dropped (no memvld pulse).
- Reads issued in the same cycle clrrdy rises are accepted.
- Read: memre_x=1 at edge t -> memdo_x holds data and memvld_x=1 for one cycle after edge t+G_PIPE-1.
  - This gives G_PIPE cycles of latency; one read per port per cycle, fully pipelined.
  - When no read is completing, memvld_x=0 and memdo_x=0.
- Write: memwe_x=1 -> RAM[memad_x]<=memdi_x at the edge.
- memwe_x and memre_x both 1 on one port: write performed; read returns the new data (write-first).
- Cross-port read of an address written by the other port in the same cycle returns the new data (forwarded).
- Same-address write on both ports in the same cycle:
  - the G_WRPRI port's data is stored and is the value returned to any same-cycle read on either port;
  - colerr=1 for one cycle after that edge.
- Different-address simultaneous writes: both stored; colerr=0.
- Address >= G_DEPTH: write dropped; read completes normally (memvld=1) with data G_RST_VAL.
- rst asserted mid-clear or mid-read: all in-flight reads are lost with no memvld pulse; behaviour restarts per reset state.
- Write-to-read hazard, later cycle: a read of an address written at edge t, issued at edge t+1 or later, returns the new data.

Test Plan:
- G_CLR_ON_RST=1, G_DEPTH=16: release rst -> clrrdy=0 for 16 cycles then 1; read all 16 addresses -> each 0x0000 with memvld.
- G_PIPE=3: write A addr5=0xBEEF, then memre_b addr5 at edge t -> memvld_b=1 and memdo_b=0xBEEF only after edge t+2; memdo_b=0 otherwise.
- Same edge: memwe_a addr9=0x1111 and memwe_b addr9=0x2222, G_WRPRI="B" -> colerr pulses once; later read of addr9 = 0x2222.
- Port A memwe_a+memre_a addr3=0x00AA, same cycle memre_b addr3 -> both ports return 0x00AA with memvld after G_PIPE cycles.
- Mid-operation: fill addr0..3, pulse clren; user write addr1=0x5555 during CLR -> dropped; after clrrdy=1, addr1 reads 0x0000.
- G_DEPTH=12, G_ADDR=4: write addr14 dropped; read addr14 -> memvld=1 with data G_RST_VAL.
- Assert rst while a G_PIPE=2 read is in flight -> no memvld pulse after release.

Source files
------------

// File: rtl/rtlmem_2rw_px.sv
// Two-port read/write memory with an inferred RAM array, a programmable read
// latency of 1..3 cycles, per-port read-valid flags, a clear engine that fills
// the array with G_RST_VAL (optionally started by reset release), and defined
// same-address collision handling with a one-cycle colerr pulse.
module rtlmem_2rw_px #(
    parameter int                 G_ADDR       = 10,
    parameter int                 G_WIDTH      = 16,
    parameter int                 G_DEPTH      = 2**G_ADDR,
    parameter int                 G_PIPE       = 1,
    parameter logic [G_WIDTH-1:0] G_RST_VAL    = {G_WIDTH{1'b0}},
    parameter string              G_WRPRI      = "A",
    parameter bit                 G_CLR_ON_RST = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clren,
    output logic               clrrdy,
    input  logic [G_ADDR-1:0]  memad_a,
    input  logic               memwe_a,
    input  logic [G_WIDTH-1:0] memdi_a,
    input  logic               memre_a,
    output logic [G_WIDTH-1:0] memdo_a,
    output logic               memvld_a,
    input  logic [G_ADDR-1:0]  memad_b,
    input  logic               memwe_b,
    input  logic [G_WIDTH-1:0] memdi_b,
    input  logic               memre_b,
    output logic [G_WIDTH-1:0] memdo_b,
    output logic               memvld_b,
    output logic               colerr
);

    localparam bit                PRI_B     = (G_WRPRI == "B");
    localparam logic [G_ADDR:0]   DEPTH_W   = (G_ADDR+1)'(G_DEPTH);
    localparam logic [G_ADDR-1:0] LAST_ADDR = G_ADDR'(G_DEPTH - 1);

    typedef enum logic {ST_IDLE, ST_CLR} state_t;

    state_t             state_q, state_d;
    logic [G_ADDR-1:0]  cnt_q, cnt_d;
    logic               colerr_q;

    // Index 0 is port A, index 1 is port B throughout
    logic [1:0][G_ADDR-1:0]  ad;
    logic [1:0][G_WIDTH-1:0] di;
    logic [1:0]              we;
    logic [1:0]              re;
    logic [1:0]              inr;
    logic [1:0]              wr_ok;
    logic                    idle;
    logic                    collision;

    logic [G_WIDTH-1:0] ram [G_DEPTH];

    // Port A's write path is shared with the clear engine
    logic               ram_we0;
    logic [G_ADDR-1:0]  ram_wa0;
    logic [G_WIDTH-1:0] ram_wd0;

    assign ad     = {memad_b, memad_a};
    assign di     = {memdi_b, memdi_a};
    assign we     = {memwe_b, memwe_a};
    assign re     = {memre_b, memre_a};
    assign idle   = (state_q == ST_IDLE);
    assign clrrdy = idle;
    assign colerr = colerr_q;

    // Range check, collision detection and write arbitration between ports
    always_comb begin
        inr = '0;
        for (int i = 0; i < 2; i++) begin
            inr[i] = ({1'b0, ad[i]} < DEPTH_W);
        end
        collision = idle & we[0] & we[1] & inr[0] & inr[1] & (ad[0] == ad[1]);
        wr_ok[0]  = idle & we[0] & inr[0] & ~(collision & PRI_B);
        wr_ok[1]  = idle & we[1] & inr[1] & ~(collision & ~PRI_B);
    end

    assign ram_we0 = ~idle | wr_ok[0];
    assign ram_wa0 = idle ? ad[0] : cnt_q;
    assign ram_wd0 = idle ? di[0] : G_RST_VAL;

    // RAM write ports; the two never hit the same word in one cycle
    always_ff @(posedge clk) begin
        if (ram_we0) begin
            ram[ram_wa0] <= ram_wd0;
        end
        if (wr_ok[1]) begin
            ram[ad[1]] <= di[1];
        end
    end

    // Clear engine state, clear address counter and collision flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= G_CLR_ON_RST ? ST_CLR : ST_IDLE;
            cnt_q    <= '0;
            colerr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            colerr_q <= collision;
        end
    end

    // Clear engine next state: sweep every address once, then return to idle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clren) begin
                    state_d = ST_CLR;
                    cnt_d   = '0;
                end
            end
            ST_CLR: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic [G_ADDR-1:0]  rd_idx;
        logic               fwd_hit;
        logic [G_WIDTH-1:0] fwd_val;
        logic [G_WIDTH-1:0] rd_raw_q;
        logic               s1_vld_q;
        logic               s1_hit_q;
        logic [G_WIDTH-1:0] s1_val_q;
        logic [G_WIDTH-1:0] s1_data;
        logic               vld_out;
        logic [G_WIDTH-1:0] dat_out;

        assign rd_idx = inr[gi] ? ad[gi] : '0;

        // Bypass value: same-cycle write data (write-first / cross-port) or the reset value out of range
        always_comb begin
            fwd_hit = 1'b0;
            fwd_val = G_RST_VAL;
            if (!inr[gi]) begin
                fwd_hit = 1'b1;
            end else if (wr_ok[0] && (ad[0] == ad[gi])) begin
                fwd_hit = 1'b1;
                fwd_val = di[0];
            end else if (wr_ok[1] && (ad[1] == ad[gi])) begin
                fwd_hit = 1'b1;
                fwd_val = di[1];
            end
        end

        // Registered RAM read; left unreset so it maps onto block RAM output registers
        always_ff @(posedge clk) begin
            rd_raw_q <= ram[rd_idx];
        end

        // First read stage: valid flag and bypass selection travel alongside the RAM read
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1_vld_q <= 1'b0;
                s1_hit_q <= 1'b0;
                s1_val_q <= '0;
            end else begin
                s1_vld_q <= idle & re[gi];
                s1_hit_q <= fwd_hit;
                s1_val_q <= fwd_val;
            end
        end

        assign s1_data = s1_vld_q ? (s1_hit_q ? s1_val_q : rd_raw_q) : '0;

        if (G_PIPE == 1) begin : g_p1
            assign vld_out = s1_vld_q;
            assign dat_out = s1_data;
        end else begin : g_pn
            logic               vld_sr_q [G_PIPE-1];
            logic [G_WIDTH-1:0] dat_sr_q [G_PIPE-1];

            // Extra latency stages, flushed by reset so in-flight reads vanish
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < G_PIPE - 1; k++) begin
                        vld_sr_q[k] <= 1'b0;
                        dat_sr_q[k] <= '0;
                    end
                end else begin
                    vld_sr_q[0] <= s1_vld_q;
                    dat_sr_q[0] <= s1_data;
                    for (int k = 1; k < G_PIPE - 1; k++) begin
                        vld_sr_q[k] <= vld_sr_q[k-1];
                        dat_sr_q[k] <= dat_sr_q[k-1];
                    end
                end
            end

            assign vld_out = vld_sr_q[G_PIPE-2];
            assign dat_out = dat_sr_q[G_PIPE-2];
        end
    end

    assign memvld_a = g_port[0].vld_out;
    assign memdo_a  = g_port[0].dat_out;
    assign memvld_b = g_port[1].vld_out;
    assign memdo_b  = g_port[1].dat_out;

endmodule

// File: tb/tb_rtlmem_2rw_px.sv
// Bench for rtlmem_2rw_px: two instances with different parameter sets share
// one stimulus stream; a word-level reference model per instance predicts
// every output every cycle.
module tb_rtlmem_2rw_px;

    logic        clk = 1'b0;
    logic        rst;
    logic        clren;
    logic [3:0]  ad_a, ad_b;
    logic        we_a, re_a, we_b, re_b;
    logic [15:0] di_a, di_b;

    logic        clrrdy [2];
    logic        vld_a  [2];
    logic        vld_b  [2];
    logic        colerr [2];
    logic [15:0] do_a   [2];
    logic [15:0] do_b   [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Instance 0: 12 words in a 4-bit space, latency 3, port B wins, clear on reset
    rtlmem_2rw_px #(
        .G_ADDR(4), .G_WIDTH(16), .G_DEPTH(12), .G_PIPE(3),
        .G_RST_VAL(16'h0000), .G_WRPRI("B"), .G_CLR_ON_RST(1'b1)
    ) u_dut0 (
        .clk(clk), .rst(rst), .clren(clren), .clrrdy(clrrdy[0]),
        .memad_a(ad_a), .memwe_a(we_a), .memdi_a(di_a), .memre_a(re_a),
        .memdo_a(do_a[0]), .memvld_a(vld_a[0]),
        .memad_b(ad_b), .memwe_b(we_b), .memdi_b(di_b), .memre_b(re_b),
        .memdo_b(do_b[0]), .memvld_b(vld_b[0]),
        .colerr(colerr[0])
    );

    // Instance 1: 16 words, latency 1, port A wins, no clear on reset
    rtlmem_2rw_px #(
        .G_ADDR(4), .G_WIDTH(16), .G_DEPTH(16), .G_PIPE(1),
        .G_RST_VAL(16'hA5A5), .G_WRPRI("A"), .G_CLR_ON_RST(1'b0)
    ) u_dut1 (
        .clk(clk), .rst(rst), .clren(clren), .clrrdy(clrrdy[1]),
        .memad_a(ad_a), .memwe_a(we_a), .memdi_a(di_a), .memre_a(re_a),
        .memdo_a(do_a[1]), .memvld_a(vld_a[1]),
        .memad_b(ad_b), .memwe_b(we_b), .memdi_b(di_b), .memre_b(re_b),
        .memdo_b(do_b[1]), .memvld_b(vld_b[1]),
        .colerr(colerr[1])
    );

    // Reference model parameters and state
    int          depth   [2] = '{12, 16};
    int          pipe    [2] = '{3, 1};
    bit          pri_b   [2] = '{1'b1, 1'b0};
    bit          clr_rst [2] = '{1'b1, 1'b0};
    logic [15:0] rst_val [2] = '{16'h0000, 16'hA5A5};
    logic [15:0] mem     [2][16];
    int          busy    [2];        // cycles of clearing still to go
    logic        sv      [2][2][3];  // pending reads: slot k completes k edges from now
    logic [15:0] sd      [2][2][3];
    logic        ecol    [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            busy[d] = clr_rst[d] ? depth[d] : 0;
            if (clr_rst[d]) begin
                for (int i = 0; i < 16; i++) mem[d][i] = rst_val[d];
            end
            for (int p = 0; p < 2; p++) begin
                for (int k = 0; k < 3; k++) begin
                    sv[d][p][k] = 1'b0;
                    sd[d][p][k] = 16'h0;
                end
            end
            ecol[d] = 1'b0;
        end
    endtask

    // One clock edge of the model, using the inputs the DUTs just sampled
    task automatic model_edge();
        logic [3:0]  a   [2];
        logic        w   [2];
        logic        r   [2];
        logic [15:0] dv  [2];
        logic        inr [2];
        logic        rv  [2];
        logic [15:0] rd  [2];
        logic        col;
        a[0] = ad_a; a[1] = ad_b;
        w[0] = we_a; w[1] = we_b;
        r[0] = re_a; r[1] = re_b;
        dv[0] = di_a; dv[1] = di_b;
        for (int d = 0; d < 2; d++) begin
            col = 1'b0;
            for (int p = 0; p < 2; p++) begin
                rv[p]  = 1'b0;
                rd[p]  = 16'h0;
                inr[p] = (int'(a[p]) < depth[d]);
            end
            if (busy[d] == 0) begin
                if (w[0] && w[1] && inr[0] && inr[1] && a[0] == a[1]) begin
                    col = 1'b1;
                    mem[d][a[0]] = pri_b[d] ? dv[1] : dv[0];
                end else begin
                    if (w[0] && inr[0]) mem[d][a[0]] = dv[0];
                    if (w[1] && inr[1]) mem[d][a[1]] = dv[1];
                end
                for (int p = 0; p < 2; p++) begin
                    if (r[p]) begin
                        rv[p] = 1'b1;
                        rd[p] = inr[p] ? mem[d][a[p]] : rst_val[d];
                    end
                end
                if (clren) begin
                    busy[d] = depth[d];
                    for (int i = 0; i < 16; i++) mem[d][i] = rst_val[d];
                end
            end else begin
                busy[d]--;
            end
            for (int p = 0; p < 2; p++) begin
                for (int k = 0; k < pipe[d] - 1; k++) begin
                    sv[d][p][k] = sv[d][p][k+1];
                    sd[d][p][k] = sd[d][p][k+1];
                end
                sv[d][p][pipe[d]-1] = rv[p];
                sd[d][p][pipe[d]-1] = rd[p];
            end
            ecol[d] = col;
        end
    endtask

    task automatic check_outputs();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_clrrdy", d), 32'(clrrdy[d]), 32'(busy[d] == 0));
            chk($sformatf("d%0d_vld_a", d), 32'(vld_a[d]), 32'(sv[d][0][0]));
            chk($sformatf("d%0d_do_a", d), 32'(do_a[d]), 32'(sv[d][0][0] ? sd[d][0][0] : 16'h0));
            chk($sformatf("d%0d_vld_b", d), 32'(vld_b[d]), 32'(sv[d][1][0]));
            chk($sformatf("d%0d_do_b", d), 32'(do_b[d]), 32'(sv[d][1][0] ? sd[d][1][0] : 16'h0));
            chk($sformatf("d%0d_colerr", d), 32'(colerr[d]), 32'(ecol[d]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drv(input logic wa, input logic [3:0] aa, input logic [15:0] da, input logic ra,
                       input logic wb, input logic [3:0] ab, input logic [15:0] db, input logic rb);
        we_a = wa; ad_a = aa; di_a = da; re_a = ra;
        we_b = wb; ad_b = ab; di_b = db; re_b = rb;
    endtask

    task automatic idle_in();
        drv(1'b0, 4'h0, 16'h0, 1'b0, 1'b0, 4'h0, 16'h0, 1'b0);
    endtask

    // Called at a falling edge; asserts reset between edges, holds it, releases at a falling edge
    task automatic do_reset();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_outputs();
        @(negedge clk);
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!(clrrdy[0] && clrrdy[1]) && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int low0;
        int low1;
        int guard;
        rst   = 1'b1;
        clren = 1'b0;
        idle_in();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) mem[d][i] = 16'h0;
        end
        model_reset();
        @(negedge clk);
        do_reset();

        // Clear lengths: instance 0 auto-clears 12 words, instance 1 is told to clear 16
        low0 = clrrdy[0] ? 0 : 1;
        low1 = clrrdy[1] ? 0 : 1;
        clren = 1'b1;
        step();
        clren = 1'b0;
        low0 += clrrdy[0] ? 0 : 1;
        low1 += clrrdy[1] ? 0 : 1;
        guard = 0;
        while (!(clrrdy[0] && clrrdy[1]) && guard < 40) begin
            step();
            low0 += clrrdy[0] ? 0 : 1;
            low1 += clrrdy[1] ? 0 : 1;
            guard++;
        end
        chk("clr_len_d0", 32'(low0), 32'd12);
        chk("clr_len_d1", 32'(low1), 32'd16);

        // Read back the whole address space on both ports after the clear
        for (int i = 0; i < 16; i++) begin
            drv(1'b0, 4'(i), 16'h0, 1'b1, 1'b0, 4'(15 - i), 16'h0, 1'b1);
            step();
        end
        idle_in();
        repeat (3) step();

        // Latency: write addr5, read it on port B, data appears only after the third edge
        drv(1'b1, 4'd5, 16'hBEEF, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
        step();
        drv(1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 4'd5, 16'h0, 1'b1);
        step();
        chk("lat_t0_vld", 32'(vld_b[0]), 32'd0);
        chk("lat_p1_do", 32'(do_b[1]), 32'hBEEF);
        idle_in();
        step();
        chk("lat_t1_vld", 32'(vld_b[0]), 32'd0);
        chk("lat_t1_do", 32'(do_b[0]), 32'd0);
        step();
        chk("lat_t2_vld", 32'(vld_b[0]), 32'd1);
        chk("lat_t2_do", 32'(do_b[0]), 32'hBEEF);
        step();
        chk("lat_t3_vld", 32'(vld_b[0]), 32'd0);

        // Same-address collision on addr9
        drv(1'b1, 4'd9, 16'h1111, 1'b0, 1'b1, 4'd9, 16'h2222, 1'b0);
        step();
        chk("col_pulse_d0", 32'(colerr[0]), 32'd1);
        chk("col_pulse_d1", 32'(colerr[1]), 32'd1);
        drv(1'b0, 4'd9, 16'h0, 1'b1, 1'b0, 4'd0, 16'h0, 1'b0);
        step();
        chk("col_end_d0", 32'(colerr[0]), 32'd0);
        chk("col_read_d1", 32'(do_a[1]), 32'h1111);
        idle_in();
        repeat (2) step();
        chk("col_read_d0", 32'(do_a[0]), 32'h2222);
        step();

        // Write-first on port A with a cross-port read of the same word
        drv(1'b1, 4'd3, 16'h00AA, 1'b1, 1'b0, 4'd3, 16'h0, 1'b1);
        step();
        chk("wf_d1_a", 32'(do_a[1]), 32'h00AA);
        chk("wf_d1_b", 32'(do_b[1]), 32'h00AA);
        idle_in();
        repeat (3) step();

        // Clear mid-operation; a write issued during the clear is dropped
        for (int i = 0; i < 4; i++) begin
            drv(1'b1, 4'(i), 16'(16'h1000 + i), 1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
            step();
        end
        idle_in();
        clren = 1'b1;
        step();
        clren = 1'b0;
        drv(1'b1, 4'd1, 16'h5555, 1'b1, 1'b0, 4'd0, 16'h0, 1'b0);
        step();
        idle_in();
        wait_ready();
        drv(1'b0, 4'd1, 16'h0, 1'b1, 1'b0, 4'd0, 16'h0, 1'b0);
        step();
        chk("clr_addr1_d1", 32'(do_a[1]), 32'hA5A5);
        idle_in();
        repeat (3) step();

        // Out-of-range address 14 on instance 0 (in range on instance 1)
        drv(1'b1, 4'd14, 16'h1234, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
        step();
        drv(1'b0, 4'd14, 16'h0, 1'b1, 1'b0, 4'd14, 16'h0, 1'b1);
        step();
        idle_in();
        repeat (2) step();
        chk("oor_vld_d0", 32'(vld_a[0]), 32'd1);
        chk("oor_do_d0", 32'(do_a[0]), 32'h0000);
        step();

        // Randomized traffic with occasional clears
        for (int n = 0; n < 2000; n++) begin
            we_a  = 1'($urandom_range(0, 1));
            re_a  = 1'($urandom_range(0, 1));
            we_b  = 1'($urandom_range(0, 1));
            re_b  = 1'($urandom_range(0, 1));
            ad_a  = 4'($urandom_range(0, 15));
            ad_b  = ($urandom_range(0, 3) == 0) ? ad_a : 4'($urandom_range(0, 15));
            di_a  = 16'($urandom);
            di_b  = 16'($urandom);
            clren = ($urandom_range(0, 63) == 0);
            step();
        end
        clren = 1'b0;
        idle_in();
        wait_ready();

        // Reset while a read is in flight: it must never complete
        drv(1'b0, 4'd2, 16'h0, 1'b1, 1'b0, 4'd7, 16'h0, 1'b1);
        step();
        idle_in();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("flush_vld_d0", 32'(vld_a[0] | vld_b[0]), 32'd0);
        end
        wait_ready();

        // Instance 1 contents survive reset; instance 0 was cleared again
        for (int i = 0; i < 16; i++) begin
            drv(1'b0, 4'(i), 16'h0, 1'b1, 1'b0, 4'(i), 16'h0, 1'b1);
            step();
        end
        idle_in();
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
